// File: rtl/simplez_seq.sv
// Simplez control sequencer. Decodes the opcode and the current phase into the
// per-cycle microorders, and counts the instructions it retires.
module simplez_seq #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      co,
  input  logic            ac_zero,
  input  logic            mem_ready,
  input  logic            run,
  output logic            lec,
  output logic            esc,
  output logic            era,
  output logic            eri,
  output logic            sri,
  output logic            scp,
  output logic            ecp,
  output logic            incp,
  output logic            eac,
  output logic            sac,
  output logic [1:0]      alu_op,
  output logic            stop,
  output logic [2:0]      state,
  output logic [CNTW-1:0] icount
);

  // state | meaning
  // I0    | fetch: read instruction into RI, bump CP when memory completes
  // I1    | decode: compute the operand address or finish a one-cycle op
  // O0    | operand access: LD/ADD read, ST write, wait on mem_ready
  // O1    | restore RA from CP for the next fetch
  // HLT   | halted, waiting for run
  typedef enum logic [2:0] {
    S_I0  = 3'd0,
    S_I1  = 3'd1,
    S_O0  = 3'd2,
    S_O1  = 3'd3,
    S_HLT = 3'd4
  } state_t;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;

  state_t          state_q;
  state_t          state_d;
  logic            retire;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_I0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // Decode is gated by rst so every strobe is quiet for the whole reset cycle.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    lec     = 1'b0;
    esc     = 1'b0;
    era     = 1'b0;
    eri     = 1'b0;
    sri     = 1'b0;
    scp     = 1'b0;
    ecp     = 1'b0;
    incp    = 1'b0;
    eac     = 1'b0;
    sac     = 1'b0;
    alu_op  = 2'b00;
    stop    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_I0: begin
          lec  = 1'b1;
          eri  = 1'b1;
          incp = mem_ready;
          if (mem_ready) state_d = S_I1;
        end
        S_I1: begin
          era = 1'b1;
          case (co)
            OP_ST, OP_LD, OP_ADD: begin
              sri     = 1'b1;
              state_d = S_O0;
            end
            OP_BR: begin
              sri     = 1'b1;
              ecp     = 1'b1;
              retire  = 1'b1;
              state_d = S_I0;
            end
            OP_BZ: begin
              sri     = ac_zero;
              ecp     = ac_zero;
              scp     = ~ac_zero;
              retire  = 1'b1;
              state_d = S_I0;
            end
            OP_CLR, OP_DEC: begin
              scp     = 1'b1;
              eac     = 1'b1;
              alu_op  = (co == OP_CLR) ? 2'b11 : 2'b10;
              retire  = 1'b1;
              state_d = S_I0;
            end
            default: begin
              scp     = 1'b1;
              retire  = 1'b1;
              state_d = S_HLT;
            end
          endcase
        end
        S_O0: begin
          case (co)
            OP_LD: begin
              lec = 1'b1;
              eac = mem_ready;
            end
            OP_ADD: begin
              lec    = 1'b1;
              eac    = mem_ready;
              alu_op = 2'b01;
            end
            OP_ST: begin
              sac = 1'b1;
              esc = 1'b1;
            end
            default: ;
          endcase
          if (mem_ready) state_d = S_O1;
        end
        S_O1: begin
          scp     = 1'b1;
          era     = 1'b1;
          retire  = 1'b1;
          state_d = S_I0;
        end
        S_HLT: begin
          stop = 1'b1;
          if (run) state_d = S_I0;
        end
        default: state_d = S_I0;
      endcase
    end
  end

  assign state  = rst ? 3'd0 : state_q;
  assign icount = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_simplez_seq.sv
// Directed bench for simplez_seq: walks each instruction class through its
// phases and compares state, microorders and the retire counter every cycle.
module tb_simplez_seq;

  // Narrow counter so the wrap can be reached in a few hundred cycles.
  localparam int CNTW = 8;

  localparam logic [2:0] ST = 3'd0, LD = 3'd1, ADD = 3'd2, BR = 3'd3,
                         BZ = 3'd4, CLR = 3'd5, DEC = 3'd6, HALT = 3'd7;

  // Bit order: lec esc era eri sri scp ecp incp eac sac alu_op[1:0] stop
  localparam logic [12:0] M_NONE   = 13'b0_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] M_I0W    = 13'b1_0_0_1_0_0_0_0_0_0_00_0;
  localparam logic [12:0] M_I0R    = 13'b1_0_0_1_0_0_0_1_0_0_00_0;
  localparam logic [12:0] M_I1OPA  = 13'b0_0_1_0_1_0_0_0_0_0_00_0;
  localparam logic [12:0] M_I1JMP  = 13'b0_0_1_0_1_0_1_0_0_0_00_0;
  localparam logic [12:0] M_I1SKIP = 13'b0_0_1_0_0_1_0_0_0_0_00_0;
  localparam logic [12:0] M_I1CLR  = 13'b0_0_1_0_0_1_0_0_1_0_11_0;
  localparam logic [12:0] M_I1DEC  = 13'b0_0_1_0_0_1_0_0_1_0_10_0;
  localparam logic [12:0] M_LDW    = 13'b1_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] M_LDR    = 13'b1_0_0_0_0_0_0_0_1_0_00_0;
  localparam logic [12:0] M_ADDW   = 13'b1_0_0_0_0_0_0_0_0_0_01_0;
  localparam logic [12:0] M_ADDR   = 13'b1_0_0_0_0_0_0_0_1_0_01_0;
  localparam logic [12:0] M_ST     = 13'b0_1_0_0_0_0_0_0_0_1_00_0;
  localparam logic [12:0] M_O1     = 13'b0_0_1_0_0_1_0_0_0_0_00_0;
  localparam logic [12:0] M_HLT    = 13'b0_0_0_0_0_0_0_0_0_0_00_1;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      co;
  logic            ac_zero;
  logic            mem_ready;
  logic            run;
  logic            lec, esc, era, eri, sri, scp, ecp, incp, eac, sac, stop;
  logic [1:0]      alu_op;
  logic [2:0]      state;
  logic [CNTW-1:0] icount;
  logic [12:0]     sig;

  int passed = 0;
  int total  = 0;
  logic [CNTW-1:0] exp_cnt = '0;

  simplez_seq #(.CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .co(co), .ac_zero(ac_zero), .mem_ready(mem_ready),
    .run(run), .lec(lec), .esc(esc), .era(era), .eri(eri), .sri(sri),
    .scp(scp), .ecp(ecp), .incp(incp), .eac(eac), .sac(sac),
    .alu_op(alu_op), .stop(stop), .state(state), .icount(icount)
  );

  assign sig = {lec, esc, era, eri, sri, scp, ecp, incp, eac, sac, alu_op, stop};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; co = ADD; ac_zero = 1'b1; mem_ready = 1'b1; run = 1'b1;
    #1;
    total++; if (sig !== M_NONE) $display("FAIL reset_outs got=%b exp=%b", sig, M_NONE); else passed++;
    total++; if (icount !== '0) $display("FAIL reset_icount got=%0d exp=0", icount); else passed++;
    tick();
    total++; if (dut.state_q !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dut.state_q); else passed++;
    rst = 1'b0; mem_ready = 1'b0; run = 1'b0;
    #1;
    total++; if (sig !== M_I0W) $display("FAIL reset_release got=%b exp=%b", sig, M_I0W); else passed++;
  endtask

  task automatic test_ld();
    co = LD; mem_ready = 1'b1; #1;
    total++; if (state !== 3'd0 || sig !== M_I0R) $display("FAIL ld_i0 st=%0d sig=%b exp=0/%b", state, sig, M_I0R); else passed++;
    tick();
    total++; if (state !== 3'd1 || sig !== M_I1OPA) $display("FAIL ld_i1 st=%0d sig=%b exp=1/%b", state, sig, M_I1OPA); else passed++;
    tick();
    total++; if (state !== 3'd2 || sig !== M_LDR) $display("FAIL ld_o0 st=%0d sig=%b exp=2/%b", state, sig, M_LDR); else passed++;
    tick();
    total++; if (state !== 3'd3 || sig !== M_O1 || icount !== exp_cnt) $display("FAIL ld_o1 st=%0d sig=%b cnt=%0d exp=3/%b/%0d", state, sig, icount, M_O1, exp_cnt); else passed++;
    tick(); exp_cnt++;
    total++; if (state !== 3'd0 || icount !== exp_cnt) $display("FAIL ld_retire st=%0d cnt=%0d exp=0/%0d", state, icount, exp_cnt); else passed++;
  endtask

  task automatic test_add_wait();
    co = ADD; mem_ready = 1'b1; tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (state !== 3'd2 || sig !== M_ADDW) $display("FAIL add_wait%0d st=%0d sig=%b exp=2/%b", i, state, sig, M_ADDW); else passed++;
      tick();
    end
    mem_ready = 1'b1; #1;
    total++; if (state !== 3'd2 || sig !== M_ADDR) $display("FAIL add_done st=%0d sig=%b exp=2/%b", state, sig, M_ADDR); else passed++;
    tick();
    total++; if (state !== 3'd3) $display("FAIL add_o1 st=%0d exp=3", state); else passed++;
    tick(); exp_cnt++;
    total++; if (state !== 3'd0 || icount !== exp_cnt) $display("FAIL add_retire st=%0d cnt=%0d exp=0/%0d", state, icount, exp_cnt); else passed++;
  endtask

  task automatic test_bz();
    co = BZ; ac_zero = 1'b1; mem_ready = 1'b1; tick();
    total++; if (sig !== M_I1JMP) $display("FAIL bz_taken got=%b exp=%b", sig, M_I1JMP); else passed++;
    tick(); exp_cnt++;
    total++; if (state !== 3'd0 || icount !== exp_cnt) $display("FAIL bz_taken_next st=%0d cnt=%0d exp=0/%0d", state, icount, exp_cnt); else passed++;
    ac_zero = 1'b0; tick();
    total++; if (sig !== M_I1SKIP) $display("FAIL bz_skip got=%b exp=%b", sig, M_I1SKIP); else passed++;
    tick(); exp_cnt++;
    co = BR; ac_zero = 1'b0; tick();
    total++; if (sig !== M_I1JMP) $display("FAIL br got=%b exp=%b", sig, M_I1JMP); else passed++;
    tick(); exp_cnt++;
    co = CLR; tick();
    total++; if (sig !== M_I1CLR) $display("FAIL clr got=%b exp=%b", sig, M_I1CLR); else passed++;
    tick(); exp_cnt++;
    total++; if (state !== 3'd0 || icount !== exp_cnt) $display("FAIL br_clr_retire st=%0d cnt=%0d exp=0/%0d", state, icount, exp_cnt); else passed++;
  endtask

  task automatic test_halt();
    co = HALT; mem_ready = 1'b1; run = 1'b0; tick();
    total++; if (sig !== M_I1SKIP) $display("FAIL halt_i1 got=%b exp=%b", sig, M_I1SKIP); else passed++;
    tick(); exp_cnt++;
    for (int i = 0; i < 10; i++) begin
      co = 3'(i); mem_ready = i[0]; ac_zero = i[1];
      #1;
      total++; if (state !== 3'd4 || sig !== M_HLT || icount !== exp_cnt) $display("FAIL halt_hold%0d st=%0d sig=%b cnt=%0d exp=4/%b/%0d", i, state, sig, icount, M_HLT, exp_cnt); else passed++;
      tick();
    end
    run = 1'b1; mem_ready = 1'b0; tick(); run = 1'b0; #1;
    total++; if (state !== 3'd0 || sig !== M_I0W || icount !== exp_cnt) $display("FAIL halt_resume st=%0d sig=%b cnt=%0d exp=0/%b/%0d", state, sig, icount, M_I0W, exp_cnt); else passed++;
  endtask

  task automatic test_reset_st();
    co = ST; mem_ready = 1'b1; tick(); tick();
    mem_ready = 1'b0; #1;
    total++; if (state !== 3'd2 || sig !== M_ST) $display("FAIL st_o0 st=%0d sig=%b exp=2/%b", state, sig, M_ST); else passed++;
    total++; if (esc & lec) $display("FAIL st_exclusive esc=%b lec=%b exp=not both", esc, lec); else passed++;
    tick();
    rst = 1'b1; #1;
    total++; if (sig !== M_NONE || icount !== '0) $display("FAIL st_rst_outs sig=%b cnt=%0d exp=%b/0", sig, icount, M_NONE); else passed++;
    tick(); rst = 1'b0; exp_cnt = '0; #1;
    total++; if (state !== 3'd0 || esc !== 1'b0 || icount !== '0 || sig !== M_I0W) $display("FAIL st_rst_after st=%0d esc=%b cnt=%0d sig=%b exp=0/0/0/%b", state, esc, icount, sig, M_I0W); else passed++;
  endtask

  task automatic test_wrap();
    co = DEC; mem_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 0) begin
        total++; if (sig !== M_I1DEC) $display("FAIL dec_i1 got=%b exp=%b", sig, M_I1DEC); else passed++;
      end
      tick(); exp_cnt++;
    end
    total++; if (icount !== 8'hFF || exp_cnt !== 8'hFF) $display("FAIL wrap_preset got=%0d exp=255", icount); else passed++;
    co = CLR; tick(); tick(); exp_cnt++;
    total++; if (icount !== 8'h00 || state !== 3'd0) $display("FAIL wrap_zero cnt=%0d st=%0d exp=0/0", icount, state); else passed++;
  endtask

  initial begin
    test_reset();
    test_ld();
    test_add_wait();
    test_bz();
    test_halt();
    test_reset_st();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simplez_seq.md
SIMPLEZ_SEQ -- requirements
Module: simplez_seq

Interface
REQ-001 The module SHALL have parameter CNTW, default 16, meaning the width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 co  input  3  opcode from RI[11:9]: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
REQ-005 ac_zero  input  1  high when AC==0.
REQ-006 mem_ready  input  1  memory completes the current lec/esc access this cycle.
REQ-007 run  input  1  resume request while halted.
REQ-008 lec, esc  output  1 each  memory read / write strobes.
REQ-009 era, eri  output  1 each  load RA from busAi / load RI from busD.
REQ-010 sri, scp  output  1 each  drive CD / CP onto busAi.
REQ-011 ecp, incp  output  1 each  load CP from busAi / increment CP.
REQ-012 eac, sac  output  1 each  load AC from ALU / drive AC onto busD.
REQ-013 alu_op  output  2  ALU function: 00 pass busD, 01 AC+busD, 10 AC-1, 11 clear.
REQ-014 stop  output  1  processor halted.
REQ-015 state  output  3  current state code, for debug.
REQ-016 icount  output  CNTW  number of retired instructions.

Function
REQ-017 The state codes SHALL be I0=0, I1=1, O0=2, O1=3, HLT=4; any other code SHALL go to I0 on the next edge.
REQ-018 Microorders SHALL be a combinational decode of state, co and ac_zero, and every microorder not listed for a state/opcode SHALL be 0.
REQ-019 I0 (fetch) SHALL assert lec, eri and alu_op=00.
REQ-020 In I0, incp SHALL be asserted only in the cycle where mem_ready=1.
REQ-021 I0 SHALL stay in I0 while mem_ready=0 and go to I1 when mem_ready=1.
REQ-022 In I1, ST, LD and ADD SHALL assert sri and era and go to O0.
REQ-023 In I1, BR, or BZ with ac_zero=1, SHALL assert sri, era and ecp and go to I0.
REQ-024 In I1, BZ with ac_zero=0 SHALL assert scp and era and go to I0.
REQ-025 In I1, CLR SHALL assert scp, era, eac and alu_op=11 and go to I0.
REQ-026 In I1, DEC SHALL assert scp, era, eac and alu_op=10 and go to I0.
REQ-027 In I1, HALT SHALL assert scp and era and go to HLT.
REQ-028 In O0, LD SHALL assert lec and alu_op=00, and ADD SHALL assert lec and alu_op=01; eac SHALL be asserted only while mem_ready=1.
REQ-029 In O0, ST SHALL assert sac and esc.
REQ-030 O0 SHALL hold while mem_ready=0 and go to O1 when mem_ready=1.
REQ-031 O1 SHALL assert scp and era and go to I0.
REQ-032 HLT SHALL assert stop, SHALL hold while run=0, and SHALL go to I0 on run=1 so execution resumes at the instruction after HALT.
REQ-033 co and ac_zero SHALL be sampled only in I1 and O0; changes in other states SHALL have no effect.
REQ-034 icount SHALL increment by 1 on every transition I1->I0, I1->HLT or O1->I0, and SHALL wrap from 2^CNTW-1 to 0.
REQ-035 mem_ready and run SHALL be ignored in every state where they are not listed.
REQ-036 esc and lec SHALL never be high in the same cycle.

Reset
REQ-037 While rst=1, every output SHALL be 0 and icount SHALL be 0.
REQ-038 On the first edge with rst=1, state SHALL become I0, regardless of state or of a pending memory wait, and the pending access SHALL be abandoned.
REQ-039 In the first cycle after rst falls, lec and eri SHALL be 1.

Verification
REQ-040 LD with mem_ready tied high -> states I0,I1,O0,O1,I0; eac=1 with alu_op=00 in O0; icount 0->1.
REQ-041 ADD with mem_ready=0 for 3 cycles in O0 -> state held in O0 with lec=1 and eac=0 for 3 cycles; eac=1 with alu_op=01 in the 4th cycle; then O1.
REQ-042 BZ with ac_zero=1 -> ecp=1 and sri=1 in I1, next state I0; BZ with ac_zero=0 -> scp=1 and ecp=0 in I1.
REQ-043 HALT -> stop=1 and held with run=0 for 10 cycles; run pulse -> I0 with lec=1, and icount unchanged during the hold.
REQ-044 rst=1 in O0 during an ST wait -> next state I0, esc=0, icount=0.
REQ-045 icount preset to 0xFFFF by executing 65535 DEC instructions, then one more retire -> icount=0x0000.
